dvi_video_timing_gen: RTL

// - Generates raster timing (hsync, vsync, data enable, pixel coordinates) for the DVI transmit path.
// - Runs on the pixel clock produced by the DVI TX clock generator.
// - Sits between that clock generator and the TMDS encoders.
// - Starts the raster only while the MMCM lock indication is high.

---
 rtl/dvi_video_timing_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dvi_video_timing_gen.sv
// -----------------------------------------------------------------------------
// dvi_video_timing_gen
// Raster timing generator for the DVI transmit path. It runs on the pixel
// clock and drives the TMDS encoders with sync, data enable and pixel
// coordinates. The raster only runs while the MMCM reports lock; losing lock
// parks the counters at (0,0) and blanks every output on the next cycle.
//
// Optional build: define DVI_VTG_TPG_EN to add the o_rgb colour-bar pattern.
//
// Ports
//   i_clk          in   pixel clock
//   w_srst         in   asynchronous active-high reset
//   i_locked       in   MMCM lock (already in the i_clk domain), raster enable
//   o_hsync        out  horizontal sync, active level H_POL
//   o_vsync        out  vertical sync, active level V_POL
//   o_de           out  data enable, high in the active region
//   o_x / o_y      out  pixel column / line, 0 while o_de=0
//   o_frame_start  out  one-cycle pulse with pixel (0,0)
//   o_rgb          out  {R,G,B} colour bars (DVI_VTG_TPG_EN builds only)
// All outputs are registered, one cycle behind the counters.
// -----------------------------------------------------------------------------
module dvi_video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic        i_clk,
    input  logic        w_srst,
    input  logic        i_locked,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start
`ifdef DVI_VTG_TPG_EN
    ,
    output logic [23:0] o_rgb
`endif
);

    localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS_C    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE_C    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_TOTAL_C = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS_C    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE_C    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_TOTAL_C = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state_reg;
    logic [11:0] h_cnt_reg, v_cnt_reg;
    logic [11:0] h_cnt_next, v_cnt_next;
    logic        hsync_reg, vsync_reg, de_reg, fs_reg;
    logic [11:0] x_reg, y_reg;

    logic        h_last, v_last;
    logic        de_next, hs_act, vs_act, fs_next;

    // Counter wrap: v_cnt steps only when h_cnt wraps.
    always_comb begin
        h_last     = (h_cnt_reg == H_TOTAL_C - 12'd1);
        v_last     = (v_cnt_reg == V_TOTAL_C - 12'd1);
        h_cnt_next = h_last ? 12'd0 : h_cnt_reg + 12'd1;
        v_cnt_next = v_cnt_reg;
        if (h_last) begin
            v_cnt_next = v_last ? 12'd0 : v_cnt_reg + 12'd1;
        end
    end

    // Decode of the current counter value; registered below.
    always_comb begin
        de_next = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
        hs_act  = (h_cnt_reg >= H_SS_C) && (h_cnt_reg < H_SE_C);
        // vsync depends on v_cnt only, so it switches with the h_cnt=0 pixel.
        vs_act  = (v_cnt_reg >= V_SS_C) && (v_cnt_reg < V_SE_C);
        fs_next = de_next && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
    end

    // IDLE keeps the counters at 0, so the first locked cycle decodes (0,0)
    // and the pulse on o_frame_start follows one cycle later.
    always_ff @(posedge i_clk or posedge w_srst) begin
        if (w_srst) begin
            state_reg <= ST_IDLE;
            h_cnt_reg <= 12'd0;
            v_cnt_reg <= 12'd0;
            hsync_reg <= ~H_POL;
            vsync_reg <= ~V_POL;
            de_reg    <= 1'b0;
            x_reg     <= 12'd0;
            y_reg     <= 12'd0;
            fs_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= i_locked ? ST_RUN : ST_IDLE;
                ST_RUN:  state_reg <= i_locked ? ST_RUN : ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
            if (i_locked) begin
                h_cnt_reg <= h_cnt_next;
                v_cnt_reg <= v_cnt_next;
                hsync_reg <= hs_act ? H_POL : ~H_POL;
                vsync_reg <= vs_act ? V_POL : ~V_POL;
                de_reg    <= de_next;
                x_reg     <= de_next ? h_cnt_reg : 12'd0;
                y_reg     <= de_next ? v_cnt_reg : 12'd0;
                fs_reg    <= fs_next;
            end else begin
                // Lock lost (or still absent): blank immediately, even mid-line.
                h_cnt_reg <= 12'd0;
                v_cnt_reg <= 12'd0;
                hsync_reg <= ~H_POL;
                vsync_reg <= ~V_POL;
                de_reg    <= 1'b0;
                x_reg     <= 12'd0;
                y_reg     <= 12'd0;
                fs_reg    <= 1'b0;
            end
        end
    end

    assign o_hsync       = hsync_reg;
    assign o_vsync       = vsync_reg;
    assign o_de          = de_reg;
    assign o_x           = x_reg;
    assign o_y           = y_reg;
    assign o_frame_start = fs_reg;

`ifdef DVI_VTG_TPG_EN
    // Eight bars of H_ACTIVE/8 pixels; bar 7 runs to the end of the line and
    // so takes any remainder. Bar index comes from a thermometer of compares.
    logic [7:1]  bar_ge;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;
    logic [23:0] rgb_reg;

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi = gi + 1) begin : g_bar_edge
            assign bar_ge[gi] = (h_cnt_reg >= 12'(gi * (H_ACTIVE / 8)));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bar_ge[i]) begin
                bar_idx = 3'(i);
            end
        end
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge i_clk or posedge w_srst) begin
        if (w_srst) begin
            rgb_reg <= 24'd0;
        end else begin
            rgb_reg <= (i_locked && de_next) ? bar_rgb : 24'd0;
        end
    end

    assign o_rgb = rgb_reg;
`endif

endmodule
